// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops. A run-time mode selects per-bit JK, parallel load,
// SR with a sticky illegal-input flag, or an up/down counter built from a toggle chain.
module jk_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             up,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qnot,
    output logic             tc,
    output logic             sr_err
);

    localparam logic [1:0] MODE_JK  = 2'b00;
    localparam logic [1:0] MODE_D   = 2'b01;
    localparam logic [1:0] MODE_SR  = 2'b10;
    localparam logic [1:0] MODE_CNT = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic             sr_err_q, sr_err_d;
    logic [WIDTH-1:0] jk_next, sr_next, cnt_next;
    // ones_below[i] / zeros_below[i]: every bit below i is 1 / 0 (bit 0 sees an empty set).
    logic [WIDTH:0]   ones_below, zeros_below;
    logic             sr_illegal;

    assign ones_below[0]  = 1'b1;
    assign zeros_below[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign ones_below[gi+1]  = ones_below[gi] & q_q[gi];
            assign zeros_below[gi+1] = zeros_below[gi] & ~q_q[gi];

            // Counting up toggles a bit when all lower bits are 1; down when all are 0.
            assign cnt_next[gi] = q_q[gi] ^ (up ? ones_below[gi] : zeros_below[gi]);

            always_comb begin
                jk_next[gi] = q_q[gi];
                unique case ({j[gi], k[gi]})
                    2'b01:   jk_next[gi] = 1'b0;
                    2'b10:   jk_next[gi] = 1'b1;
                    2'b11:   jk_next[gi] = ~q_q[gi];
                    default: jk_next[gi] = q_q[gi];
                endcase
            end

            // The illegal j=k=1 pair leaves its bit untouched.
            always_comb begin
                sr_next[gi] = q_q[gi];
                unique case ({j[gi], k[gi]})
                    2'b01:   sr_next[gi] = 1'b0;
                    2'b10:   sr_next[gi] = 1'b1;
                    default: sr_next[gi] = q_q[gi];
                endcase
            end
        end
    endgenerate

    assign sr_illegal = |(j & k);

    always_comb begin
        q_d = q_q;
        if (en) begin
            unique case (mode)
                MODE_JK:  q_d = jk_next;
                MODE_D:   q_d = j;
                MODE_SR:  q_d = sr_next;
                MODE_CNT: q_d = cnt_next;
                default:  q_d = q_q;
            endcase
        end
    end

    // A set on the same edge as a clear wins.
    always_comb begin
        sr_err_d = sr_err_q;
        if (en && (mode == MODE_SR) && sr_illegal) begin
            sr_err_d = 1'b1;
        end else if (clr_err) begin
            sr_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q      <= RESET_VAL;
            sr_err_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            sr_err_q <= sr_err_d;
        end
    end

    assign q      = q_q;
    assign qnot   = ~q_q;
    assign sr_err = sr_err_q;
    assign tc     = en && (mode == MODE_CNT) &&
                    (up ? ones_below[WIDTH] : zeros_below[WIDTH]);

endmodule
